// File: rtl/hcsr04_pkg.sv
// Shared state encoding, scale constants and distance conversion for the HC-SR04 ranger.
package hcsr04_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_TRIG    = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_MEASURE = 3'd3;
    localparam state_t ST_DONE    = 3'd4;
    localparam state_t ST_HOLD    = 3'd5;

    // 11239 / 65536 ~= 0.1715 mm/us: speed of sound over the round trip.
    localparam int unsigned SCALE_MM    = 11239;
    localparam int unsigned SCALE_SHIFT = 16;

    function automatic logic [15:0] echo_to_mm(input logic [15:0] echo_us);
        logic [29:0] prod;
        prod = 30'(echo_us) * 30'(SCALE_MM);
        return 16'(prod >> SCALE_SHIFT);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous echo line into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranger controller: periodic trigger, echo timing, distance in mm.
// Define HCSR04_AVG_EN to report the mean of the last four computed distances.
module hcsr04_ranger
    import hcsr04_pkg::*;
#(
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned PERIOD_US  = 60000,
    parameter int unsigned TIMEOUT_US = 25000,
    parameter int unsigned DIST_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              us_tick,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] dist_mm,
    output logic              dist_valid,
    output logic              timeout
);

    localparam int unsigned PW = $clog2(PERIOD_US + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_US + 1);

    localparam logic [PW-1:0] TRIG_LAST   = PW'(TRIG_US - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_US - 1);
    localparam logic [WW-1:0] WAIT_LAST   = WW'(TIMEOUT_US - 1);
    localparam logic [15:0]   ECHO_LIMIT  = 16'(TIMEOUT_US);

    logic echo_s;
    logic echo_prev;
    logic rise;
    logic fall;

    state_t        state, state_nx;
    logic [PW-1:0] period_cnt, period_cnt_nx;
    logic [WW-1:0] wait_cnt, wait_cnt_nx;
    logic [15:0]   echo_us, echo_us_nx;
    logic [15:0]   echo_inc;
    logic          fail_nx;

    logic [DIST_W-1:0] dist_raw;
    logic [DIST_W-1:0] dist_new;

    sync_2ff u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (echo),
        .q    (echo_s)
    );

    assign rise = echo_s & ~echo_prev;
    assign fall = ~echo_s & echo_prev;

    always_comb begin
        state_nx      = state;
        period_cnt_nx = period_cnt + PW'(us_tick);
        wait_cnt_nx   = wait_cnt;
        echo_us_nx    = echo_us;
        fail_nx       = 1'b0;
        // A tick landing on the deciding cycle is always counted first.
        echo_inc      = echo_us + 16'(us_tick);

        unique case (state)
            ST_IDLE: begin
                period_cnt_nx = '0;
                if (us_tick) begin
                    state_nx = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (us_tick && period_cnt == TRIG_LAST) begin
                    state_nx    = ST_WAIT;
                    wait_cnt_nx = '0;
                end
            end
            ST_WAIT: begin
                if (rise) begin
                    state_nx   = ST_MEASURE;
                    echo_us_nx = 16'(us_tick);
                end else if (us_tick) begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_nx = ST_HOLD;
                        fail_nx  = 1'b1;
                    end else begin
                        wait_cnt_nx = wait_cnt + 1'b1;
                    end
                end
            end
            ST_MEASURE: begin
                echo_us_nx = echo_inc;
                if (echo_inc >= ECHO_LIMIT) begin
                    state_nx = ST_HOLD;
                    fail_nx  = 1'b1;
                end else if (fall) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (us_tick && period_cnt == PERIOD_LAST) begin
                    state_nx      = ST_TRIG;
                    period_cnt_nx = '0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign dist_raw = DIST_W'(echo_to_mm(echo_us));

`ifdef HCSR04_AVG_EN
    logic [DIST_W-1:0] hist0, hist1, hist2;
    logic [DIST_W+1:0] dist_sum;

    assign dist_sum = (DIST_W+2)'(dist_raw) + (DIST_W+2)'(hist0)
                    + (DIST_W+2)'(hist1) + (DIST_W+2)'(hist2);
    assign dist_new = dist_sum[DIST_W+1:2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist0 <= '0;
            hist1 <= '0;
            hist2 <= '0;
        end else if (state == ST_DONE) begin
            hist0 <= dist_raw;
            hist1 <= hist0;
            hist2 <= hist1;
        end
    end
`else
    assign dist_new = dist_raw;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            period_cnt <= '0;
            wait_cnt   <= '0;
            echo_us    <= '0;
            echo_prev  <= 1'b0;
            trig       <= 1'b0;
            timeout    <= 1'b0;
            dist_valid <= 1'b0;
            dist_mm    <= '0;
        end else begin
            state      <= state_nx;
            period_cnt <= period_cnt_nx;
            wait_cnt   <= wait_cnt_nx;
            echo_us    <= echo_us_nx;
            echo_prev  <= echo_s;
            trig       <= (state_nx == ST_TRIG);
            timeout    <= fail_nx;
            dist_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                dist_mm <= dist_new;
            end
        end
    end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Scoreboard bench for hcsr04_ranger: random tick gaps and echo widths against a tick-level model.
module tb_hcsr04_ranger;

    localparam int unsigned TRIG_US    = 10;
    localparam int unsigned PERIOD_US  = 11700;
    localparam int unsigned TIMEOUT_US = 5840;
    localparam int unsigned DIST_W     = 16;

    logic              clk;
    logic              rstn;
    logic              us_tick;
    logic              echo;
    logic              trig;
    logic [DIST_W-1:0] dist_mm;
    logic              dist_valid;
    logic              timeout;

    hcsr04_ranger #(
        .TRIG_US    (TRIG_US),
        .PERIOD_US  (PERIOD_US),
        .TIMEOUT_US (TIMEOUT_US),
        .DIST_W     (DIST_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .us_tick    (us_tick),
        .echo       (echo),
        .trig       (trig),
        .dist_mm    (dist_mm),
        .dist_valid (dist_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_to;
        int unsigned val;
    } exp_t;

    exp_t        sb[$];
    int unsigned hist[$];
    int unsigned cur_dist;
    int          tests  = 0;
    int          failed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    endtask

    // Reference model: distance straight from the echo duration in microseconds.
    task automatic model_reset();
        hist     = '{0, 0, 0, 0};
        cur_dist = 0;
    endtask

    task automatic push_dist(input int unsigned n_us);
        int unsigned raw;
        exp_t        e;
        raw = (n_us * 11239) / 65536;
`ifdef HCSR04_AVG_EN
        hist.push_front(raw);
        void'(hist.pop_back());
        cur_dist = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
        cur_dist = raw;
`endif
        cur_dist = cur_dist % 65536;
        e.is_to  = 1'b0;
        e.val    = cur_dist;
        sb.push_back(e);
    endtask

    task automatic push_timeout();
        exp_t e;
        e.is_to = 1'b1;
        e.val   = cur_dist;
        sb.push_back(e);
    endtask

    // Driver: inputs change on the falling edge.
    task automatic tick_cycle(input bit quiet);
        @(negedge clk);
        us_tick = !quiet && ($urandom_range(15) != 0);
    endtask

    task automatic run_ticks(input int unsigned n);
        int unsigned got = 0;
        while (got < n) begin
            tick_cycle(1'b0);
            if (us_tick) got++;
        end
    endtask

    // No ticks around an echo edge, so the measured width is exactly the ticks issued while high.
    task automatic set_echo(input bit v);
        @(negedge clk);
        us_tick = 1'b0;
        echo    = v;
        repeat (5) tick_cycle(1'b1);
    endtask

    task automatic wait_trig_fall();
        int unsigned n   = 0;
        bit          seen = 1'b0;
        while (n < 30000) begin
            tick_cycle(1'b0);
            n++;
            if (trig) seen = 1'b1;
            else if (seen) return;
        end
        failed++;
        tests++;
        $display("FAIL trig_wait: got no trigger pulse within %0d cycles, required one", n);
        finish_run();
    endtask

    task automatic measure(input int unsigned n_us);
        wait_trig_fall();
        run_ticks($urandom_range(20, 300));
        set_echo(1'b1);
        run_ticks(n_us);
        push_dist(n_us);
        set_echo(1'b0);
    endtask

    // Monitor: samples 1 time unit after the rising edge, with its own tick count.
    int unsigned ticks     = 0;
    int unsigned rise_tick = 0;
    int unsigned fall_tick = 0;
    bit          have_rise = 1'b0;
    bit          prev_trig = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (!rstn) begin
            have_rise = 1'b0;
            prev_trig = 1'b0;
        end else begin
            if (us_tick) ticks++;
            if (trig && !prev_trig) begin
                if (have_rise) check("trig_period", ticks - rise_tick, PERIOD_US);
                rise_tick = ticks;
                have_rise = 1'b1;
            end
            if (!trig && prev_trig) begin
                check("trig_width", ticks - rise_tick, TRIG_US);
                fall_tick = ticks;
            end
            prev_trig = trig;

            if (dist_valid || timeout) begin
                if (dist_valid && timeout) check("pulse_overlap", 1, 0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {dist_valid, timeout}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_kind", timeout, e.is_to);
                    if (e.is_to) begin
                        check("timeout_gap", ticks - fall_tick, TIMEOUT_US);
                        check("timeout_dist_held", dist_mm, e.val);
                    end else begin
                        check("dist_mm", dist_mm, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #950000;
        failed++;
        tests++;
        $display("FAIL watchdog: got no end of run by %0t, required earlier finish", $time);
        finish_run();
    end

    initial begin
        int unsigned n;
        rstn    = 1'b0;
        echo    = 1'b0;
        us_tick = 1'b0;
        model_reset();
        #1;
        check("reset_trig", trig, 0);
        check("reset_dist", dist_mm, 0);
        check("reset_valid", dist_valid, 0);
        check("reset_timeout", timeout, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        measure(1000);
        measure(5830);
        measure($urandom_range(20, 5000));
        measure($urandom_range(20, 5000));

        wait_trig_fall();
        push_timeout();

        // Abort mid-measurement at 500 us of echo.
        wait_trig_fall();
        run_ticks($urandom_range(20, 300));
        set_echo(1'b1);
        run_ticks(500);
        @(negedge clk);
        us_tick = 1'b0;
        rstn    = 1'b0;
        #1;
        check("abort_trig", trig, 0);
        check("abort_dist", dist_mm, 0);
        check("abort_valid", dist_valid, 0);
        check("abort_timeout", timeout, 0);
        check("abort_no_pending", sb.size(), 0);
        model_reset();
        repeat (4) @(negedge clk);
        rstn = 1'b1;

        // Echo now stuck high from reset: never a rise, so a wait timeout.
        push_timeout();
        n = 0;
        while (sb.size() != 0 && n < 20000) begin
            tick_cycle(1'b0);
            n++;
        end
        repeat (4) tick_cycle(1'b0);
        check("drain_queue", sb.size(), 0);
        check("stuck_dist", dist_mm, 0);
        finish_run();
    end

endmodule

// File: doc/hcsr04_ranger.md
HCSR04_RANGER -- requirements
Module: hcsr04_ranger

Interface
REQ-001 SHALL have parameter TRIG_US, default 10, trigger pulse width in us_tick periods.
REQ-002 SHALL have parameter PERIOD_US, default 60000, measurement cycle length in us_tick periods.
REQ-003 SHALL have parameter TIMEOUT_US, default 25000, limit for both the echo-rise wait and the echo-high width.
REQ-004 SHALL have parameter DIST_W, default 16, dist_mm width.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port us_tick, input, 1, one-clk strobe once per microsecond.
REQ-008 SHALL have port echo, input, 1, sensor echo line, asynchronous to clk.
REQ-009 SHALL have port trig, output, 1, sensor trigger, registered.
REQ-010 SHALL have port dist_mm, output, DIST_W, last distance in millimetres, registered.
REQ-011 SHALL have port dist_valid, output, 1, one-clk pulse when dist_mm updates.
REQ-012 SHALL have port timeout, output, 1, one-clk pulse when a cycle fails.

Function
REQ-013 SHALL pass echo through a 2-flop synchronizer; all echo decisions use the synchronized value; rising/falling edges are detected against a third registered copy.
REQ-014 SHALL implement FSM states IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLD.
REQ-015 IDLE -> TRIG on the first us_tick; the period counter clears and starts counting us_tick on entering TRIG.
REQ-016 trig SHALL be high exactly while in TRIG; TRIG -> WAIT_RISE after TRIG_US us_ticks.
REQ-017 WAIT_RISE -> MEASURE on a synchronized echo rising edge; echo already high on entry is not a rise.
REQ-018 WAIT_RISE -> HOLD with a timeout pulse when TIMEOUT_US us_ticks elapse without a rise.
REQ-019 MEASURE SHALL count us_ticks into a 16-bit echo_us counter; a falling edge -> DONE.
REQ-020 MEASURE -> HOLD with a timeout pulse when echo_us reaches TIMEOUT_US; dist_mm is unchanged.
REQ-021 DONE SHALL compute dist_mm = (echo_us * 11239) >> 16 (30-bit product, truncated), register it, and pulse dist_valid in the same cycle; DONE -> HOLD next clk.
REQ-022 HOLD -> TRIG when the period counter reaches PERIOD_US; TRIG-to-TRIG spacing is exactly PERIOD_US us_ticks.
REQ-023 SHALL require TRIG_US + 2*TIMEOUT_US < PERIOD_US; the period counter never wraps within a cycle.
REQ-024 An echo edge coinciding with a us_tick SHALL count that tick before the state changes.
REQ-025 dist_valid and timeout SHALL never assert in the same cycle.

Reset
REQ-026 On rstn low: state IDLE; trig, dist_valid and timeout 0; dist_mm 0; all counters and synchronizer flops 0.
REQ-027 Reset mid-MEASURE SHALL abort the cycle with no dist_valid or timeout pulse; the next cycle starts from IDLE.

Configuration
REQ-028 Macro HCSR04_AVG_EN, when defined: dist_mm SHALL be the sum of the last 4 computed distances >> 2; the history resets to 0 and updates only in DONE.
REQ-029 Without HCSR04_AVG_EN, dist_mm SHALL be the single latest computed distance.

Structure
REQ-030 Package hcsr04_pkg SHALL hold the FSM state enum, the scale constant 11239, and the shift constant 16.
REQ-031 Sub-module sync_2ff SHALL implement the echo synchronizer.

Verification
REQ-032 Echo high 1000 us after a rise -> dist_valid pulse, dist_mm = 171.
REQ-033 Echo high 5830 us -> dist_mm = 999; with HCSR04_AVG_EN, after 4 such cycles from reset -> 999, and after the first cycle -> 249.
REQ-034 Echo never rises -> timeout pulse 25000 us_ticks after trig falls, no dist_valid, next trig at tick 60000.
REQ-035 Echo stuck high from reset -> no MEASURE entry, timeout in WAIT_RISE, dist_mm stays 0.
REQ-036 Trig timing -> high for exactly 10 us_ticks; consecutive rising edges 60000 us_ticks apart.
REQ-037 rstn asserted at echo_us = 500 -> all outputs 0 immediately, no pulses, fresh trig after release.
